// File: rtl/add_round_key_stream_if.sv
// rtl/add_round_key_stream_if.sv - state-in / result-out handshake bundle for the AddRoundKey engine
interface add_round_key_stream_if #(
  parameter int NB         = 4,
  parameter int ROUND_KEYS = 11
) ();
  localparam int SW = 32 * NB;
  localparam int RW = (ROUND_KEYS > 1) ? $clog2(ROUND_KEYS) : 1;

  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_state;
  logic [RW-1:0] s_round;
  logic          m_valid;
  logic          m_ready;
  logic [SW-1:0] m_state;
  logic          m_err;

  modport master (
    output s_valid, s_state, s_round, m_ready,
    input  s_ready, m_valid, m_state, m_err
  );

  modport slave (
    input  s_valid, s_state, s_round, m_ready,
    output s_ready, m_valid, m_state, m_err
  );
endinterface

// File: rtl/add_round_key_stream.sv
// rtl/add_round_key_stream.sv - multi-beat AES AddRoundKey engine with a writable round-key buffer
module add_round_key_stream #(
  parameter int NB         = 4,
  parameter int LANES      = 1,
  parameter int ROUND_KEYS = 11,
  localparam int SW        = 32 * NB,
  localparam int RW        = (ROUND_KEYS > 1) ? $clog2(ROUND_KEYS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_we,
  input  logic [RW-1:0]          key_waddr,
  input  logic [SW-1:0]          key_wdata,
  output logic                   key_wr_err,
  add_round_key_stream_if.slave  bus
);
  localparam int BEATS = NB / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [RW:0] RK_LIM = (RW + 1)'(ROUND_KEYS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MIX  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] work_q, work_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic          err_q, err_d;
  logic [SW-1:0] mstate_q, mstate_d;
  logic          mvalid_q, mvalid_d;
  logic          wr_err_q, wr_err_d;
  logic [SW-1:0] keys_q [ROUND_KEYS];

  logic [SW-1:0] key_sel;
  logic [SW-1:0] mixed;
  logic          last_beat;
  logic          key_wr_ok;

  // An out-of-range round is flagged and mixed against zero, so the state passes through.
  always_comb begin
    key_sel = '0;
    if (!err_q && ({1'b0, rnd_q} < RK_LIM)) begin
      key_sel = keys_q[rnd_q];
    end
  end

  always_comb begin
    mixed = work_q;
    for (int c = 0; c < NB; c++) begin
      if ((c / LANES) == int'(beat_q)) begin
        mixed[32*c +: 32] = work_q[32*c +: 32] ^ key_sel[32*c +: 32];
      end
    end
  end

  assign last_beat = (beat_q == BW'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    work_d   = work_q;
    rnd_d    = rnd_q;
    err_d    = err_q;
    mstate_d = mstate_q;
    mvalid_d = mvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid) begin
          state_d = ST_MIX;
          work_d  = bus.s_state;
          rnd_d   = bus.s_round;
          beat_d  = '0;
          err_d   = !({1'b0, bus.s_round} < RK_LIM);
        end
      end
      ST_MIX: begin
        work_d = mixed;
        if (last_beat) begin
          state_d  = ST_HOLD;
          beat_d   = '0;
          mvalid_d = 1'b1;
          mstate_d = mixed;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.m_ready) begin
          state_d  = ST_IDLE;
          mvalid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The slot being mixed is write-protected only while beats are still reading it.
  always_comb begin
    key_wr_ok = key_we && ({1'b0, key_waddr} < RK_LIM)
                && !((state_q == ST_MIX) && (key_waddr == rnd_q));
    wr_err_d  = key_we && !key_wr_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      work_q   <= '0;
      rnd_q    <= '0;
      err_q    <= 1'b0;
      mstate_q <= '0;
      mvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      work_q   <= work_d;
      rnd_q    <= rnd_d;
      err_q    <= err_d;
      mstate_q <= mstate_d;
      mvalid_q <= mvalid_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ROUND_KEYS; k++) begin
        keys_q[k] <= '0;
      end
    end else if (key_wr_ok) begin
      keys_q[key_waddr] <= key_wdata;
    end
  end

  assign bus.s_ready = (state_q == ST_IDLE);
  assign bus.m_valid = mvalid_q;
  assign bus.m_state = mstate_q;
  assign bus.m_err   = err_q;
  assign key_wr_err  = wr_err_q;
endmodule

// File: tb/tb_add_round_key_stream.sv
// tb/tb_add_round_key_stream.sv - directed-vector bench for add_round_key_stream (LANES=1 and LANES=4)
module tb_add_round_key_stream;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_IN  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ALL_A    = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] ALL_5    = 128'h55555555555555555555555555555555;
  localparam logic [127:0] ALL_F    = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] S_VEC    = 128'hffffffff00000000ffffffff00000000;
  localparam logic [127:0] K2       = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K3       = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] S_XOR_K2 = 128'hffeeddcc4455667777665544ccddeeff;
  localparam logic [127:0] S_XOR_K3 = 128'hfedcba9889abcdeffedcba9889abcdef;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_we;
  logic [3:0]   key_waddr;
  logic [127:0] key_wdata;
  logic         kerr1, kerr4;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  add_round_key_stream_if #(.NB(4), .ROUND_KEYS(11)) if1 ();
  add_round_key_stream_if #(.NB(4), .ROUND_KEYS(11)) if4 ();

  add_round_key_stream #(.NB(4), .LANES(1), .ROUND_KEYS(11)) dut1 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr),
    .key_wdata(key_wdata), .key_wr_err(kerr1), .bus(if1.slave)
  );

  add_round_key_stream #(.NB(4), .LANES(4), .ROUND_KEYS(11)) dut4 (
    .clk(clk), .rst(rst), .key_we(key_we), .key_waddr(key_waddr),
    .key_wdata(key_wdata), .key_wr_err(kerr4), .bus(if4.slave)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic write_key(input logic [3:0] addr, input logic [127:0] data);
    @(negedge clk);
    key_we    = 1'b1;
    key_waddr = addr;
    key_wdata = data;
    @(negedge clk);
    key_we    = 1'b0;
  endtask

  task automatic wait_result(inout int lat, output logic [127:0] res, output logic err);
    while (!if1.m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = if1.m_state;
    err = if1.m_err;
  endtask

  task automatic send1(input logic [127:0] st, input logic [3:0] rnd,
                       output logic [127:0] res, output logic err, output int lat);
    @(negedge clk);
    if1.s_valid = 1'b1;
    if1.s_state = st;
    if1.s_round = rnd;
    @(negedge clk);
    if1.s_valid = 1'b0;
    lat = 0;
    wait_result(lat, res, err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] res;
    logic         err;
    int           lat, lat1, lat4, bad;

    rst = 1'b1;
    key_we = 1'b0; key_waddr = '0; key_wdata = '0;
    if1.s_valid = 1'b0; if1.s_state = '0; if1.s_round = '0; if1.m_ready = 1'b1;
    if4.s_valid = 1'b0; if4.s_state = '0; if4.s_round = '0; if4.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", {if4.s_ready, if1.s_ready}, 2'b11);
    check("rst_m_valid", {if4.m_valid, if1.m_valid}, 2'b00);
    check("rst_m_state", if1.m_state, '0);
    check("rst_m_err", if1.m_err, 1'b0);
    check("rst_key_wr_err", kerr1, 1'b0);

    write_key(4'd0, FIPS_KEY);

    // FIPS-197 vector on both lane configurations, held under backpressure
    @(negedge clk);
    if1.m_ready = 1'b0; if4.m_ready = 1'b0;
    if1.s_valid = 1'b1; if1.s_state = FIPS_IN; if1.s_round = 4'd0;
    if4.s_valid = 1'b1; if4.s_state = FIPS_IN; if4.s_round = 4'd0;
    @(negedge clk);
    if1.s_valid = 1'b0; if4.s_valid = 1'b0;
    check("accept_no_valid", {if4.m_valid, if1.m_valid}, 2'b00);
    lat1 = 0; lat4 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (lat1 == 0 && if1.m_valid) lat1 = n;
      if (lat4 == 0 && if4.m_valid) lat4 = n;
      if (lat1 != 0 && lat4 != 0) break;
    end
    check("fips_lat_lanes1", lat1, 4);
    check("fips_lat_lanes4", lat4, 1);
    check("fips_state_lanes1", if1.m_state, FIPS_OUT);
    check("fips_state_lanes4", if4.m_state, FIPS_OUT);
    check("fips_err", {if4.m_err, if1.m_err}, 2'b00);

    if1.s_valid = 1'b1; if1.s_state = ALL_A; if1.s_round = 4'd1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!if1.m_valid || if1.m_state !== FIPS_OUT || if1.s_ready
          || !if4.m_valid || if4.m_state !== FIPS_OUT || if4.s_ready) bad++;
    end
    check("backpressure_stable", bad, 0);
    if1.s_valid = 1'b0;
    if1.m_ready = 1'b1; if4.m_ready = 1'b1;
    @(negedge clk);
    check("release_m_valid", {if4.m_valid, if1.m_valid}, 2'b00);
    check("release_s_ready", {if4.s_ready, if1.s_ready}, 2'b11);
    check("release_holds_state", if1.m_state, FIPS_OUT);
    @(negedge clk);
    check("no_second_accept", if1.m_valid, 1'b0);

    send1(ALL_A, 4'd15, res, err, lat);
    check("bad_round_state", res, ALL_A);
    check("bad_round_err", err, 1'b1);
    check("bad_round_lat", lat, 4);

    write_key(4'd12, ALL_F);
    check("oob_write_err", kerr1, 1'b1);
    @(negedge clk);
    check("oob_write_err_pulse", kerr1, 1'b0);

    // Writes during MIX: active slot is protected, other slots land
    write_key(4'd2, K2);
    @(negedge clk);
    if1.s_valid = 1'b1; if1.s_state = S_VEC; if1.s_round = 4'd2;
    @(negedge clk);
    if1.s_valid = 1'b0;
    key_we = 1'b1; key_waddr = 4'd2; key_wdata = ALL_F;
    @(negedge clk);
    check("mix_write_drop_err", kerr1, 1'b1);
    key_waddr = 4'd3; key_wdata = K3;
    @(negedge clk);
    check("mix_write_other_ok", kerr1, 1'b0);
    key_we = 1'b0;
    lat = 2;
    wait_result(lat, res, err);
    check("mix_write_lat", lat, 4);
    check("mix_write_old_key", res, S_XOR_K2);
    send1(S_VEC, 4'd3, res, err, lat);
    check("slot3_written", res, S_XOR_K3);
    send1(S_VEC, 4'd2, res, err, lat);
    check("slot2_kept", res, S_XOR_K2);

    @(negedge clk);
    if1.s_valid = 1'b1; if1.s_state = ALL_A; if1.s_round = 4'd4;
    key_we = 1'b1; key_waddr = 4'd4; key_wdata = ALL_5;
    @(negedge clk);
    if1.s_valid = 1'b0; key_we = 1'b0;
    lat = 0;
    wait_result(lat, res, err);
    check("same_edge_new_key", res, ALL_F);

    // Reset while dut1 is in beat 2
    @(negedge clk);
    if1.s_valid = 1'b1; if1.s_state = FIPS_IN; if1.s_round = 4'd0;
    @(negedge clk);
    if1.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmix_rst_m_valid", if1.m_valid, 1'b0);
    check("midmix_rst_s_ready", if1.s_ready, 1'b1);
    check("midmix_rst_m_state", if1.m_state, '0);
    rst = 1'b0;
    @(negedge clk);
    send1(FIPS_IN, 4'd0, res, err, lat);
    check("post_rst_slot0_zero", res, FIPS_IN);
    check("post_rst_lat", lat, 4);
    send1(S_VEC, 4'd3, res, err, lat);
    check("post_rst_slot3_zero", res, S_VEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
